// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack sequencer: op codes, FSM encoding,
// empty-stack pointer value and a small op classification helper.
package stack_ctrl_pkg;

   localparam logic [1:0] OP_PUSH = 2'd0;
   localparam logic [1:0] OP_POP  = 2'd1;
   localparam logic [1:0] OP_CALL = 2'd2;
   localparam logic [1:0] OP_RET  = 2'd3;

   localparam logic [7:0] SP_INIT = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MEM     = 3'd1,
      ST_SP_WB   = 3'd2,
      ST_DATA_WB = 3'd3,
      ST_PC_LD   = 3'd4
   } state_t;

   // PUSH and CALL write memory and move SP down; POP and RET read and move SP up.
   function automatic logic is_write_op(input logic [1:0] op);
      return (op == OP_PUSH) || (op == OP_CALL);
   endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer in the MEM stage. Owns the data
// memory request during a stack op, writes SP (and POP data) to the register
// file, and redirects the PC for CALL/RET. All outputs except op_ready are
// registered: the combinational block computes next-cycle output values.
module stack_ctrl
   import stack_ctrl_pkg::*;
#(
   parameter logic [7:0] SP_INIT = stack_ctrl_pkg::SP_INIT,
   parameter logic [1:0] SP_REG  = 2'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic [1:0] op_code,
   input  logic [7:0] src_data,
   input  logic [7:0] ret_addr,
   input  logic [1:0] dst_reg,
   input  logic [7:0] sp_in,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   output logic       mem_re,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready,
   output logic [1:0] rf_waddr,
   output logic [7:0] rf_wdata,
   output logic       rf_wr_en,
   output logic       pc_load,
   output logic [7:0] pc_value,
   output logic       done,
   output logic       stk_ovf,
   output logic       stk_unf
);

   state_t     state, state_nxt;

   // Operation context captured in the accept cycle
   logic [1:0] op_q;
   logic [7:0] src_q;
   logic [1:0] dst_q;
   logic [7:0] sp_q;
   logic [7:0] rdata_q;
   logic       capture;

   // Next-cycle values of the registered outputs
   logic [7:0] mem_addr_nxt, mem_wdata_nxt;
   logic       mem_we_nxt, mem_re_nxt;
   logic [1:0] rf_waddr_nxt;
   logic [7:0] rf_wdata_nxt;
   logic       rf_wr_en_nxt;
   logic       pc_load_nxt;
   logic [7:0] pc_value_nxt;
   logic       done_nxt;
   logic       ovf_nxt, unf_nxt;

   // Bounds check against the live SP in the accept cycle
   logic       wr_in, ovf_in, unf_in;

   assign wr_in    = is_write_op(op_code);
   assign ovf_in   = wr_in && (sp_in == 8'h00);
   assign unf_in   = !wr_in && (sp_in == SP_INIT);
   assign op_ready = (state == ST_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // Next state and next registered output values
   always_comb begin
      state_nxt     = state;
      capture       = 1'b0;
      mem_addr_nxt  = 8'h00;
      mem_wdata_nxt = 8'h00;
      mem_we_nxt    = 1'b0;
      mem_re_nxt    = 1'b0;
      rf_waddr_nxt  = 2'd0;
      rf_wdata_nxt  = 8'h00;
      rf_wr_en_nxt  = 1'b0;
      pc_load_nxt   = 1'b0;
      pc_value_nxt  = 8'h00;
      done_nxt      = 1'b0;
      ovf_nxt       = stk_ovf;
      unf_nxt       = stk_unf;
      case (state)
         ST_IDLE: begin
            if (op_valid) begin
               if (ovf_in) begin
                  ovf_nxt = 1'b1;
               end else if (unf_in) begin
                  unf_nxt = 1'b1;
               end else begin
                  state_nxt     = ST_MEM;
                  capture       = 1'b1;
                  mem_we_nxt    = wr_in;
                  mem_re_nxt    = !wr_in;
                  mem_addr_nxt  = wr_in ? sp_in : sp_in + 8'd1;
                  if (op_code == OP_PUSH)      mem_wdata_nxt = src_data;
                  else if (op_code == OP_CALL) mem_wdata_nxt = ret_addr;
               end
            end
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_nxt    = ST_SP_WB;
               rf_wr_en_nxt = 1'b1;
               rf_waddr_nxt = SP_REG;
               rf_wdata_nxt = is_write_op(op_q) ? sp_q - 8'd1 : sp_q + 8'd1;
               done_nxt     = (op_q == OP_PUSH);
            end else begin
               // Hold the request stable until the memory accepts it
               mem_addr_nxt  = mem_addr;
               mem_wdata_nxt = mem_wdata;
               mem_we_nxt    = mem_we;
               mem_re_nxt    = mem_re;
            end
         end
         ST_SP_WB: begin
            case (op_q)
               OP_POP: begin
                  state_nxt    = ST_DATA_WB;
                  rf_wr_en_nxt = 1'b1;
                  rf_waddr_nxt = dst_q;
                  rf_wdata_nxt = rdata_q;
                  done_nxt     = 1'b1;
               end
               OP_CALL, OP_RET: begin
                  state_nxt    = ST_PC_LD;
                  pc_load_nxt  = 1'b1;
                  pc_value_nxt = (op_q == OP_CALL) ? src_q : rdata_q;
                  done_nxt     = 1'b1;
               end
               default: state_nxt = ST_IDLE;
            endcase
         end
         ST_DATA_WB: state_nxt = ST_IDLE;
         ST_PC_LD:   state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Capture operation context on accept and read data on the ready edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= OP_PUSH;
         src_q   <= 8'h00;
         dst_q   <= 2'd0;
         sp_q    <= 8'h00;
         rdata_q <= 8'h00;
      end else begin
         if (capture) begin
            op_q  <= op_code;
            src_q <= src_data;
            dst_q <= dst_reg;
            sp_q  <= sp_in;
         end
         if (state == ST_MEM && mem_ready) rdata_q <= mem_rdata;
      end
   end

   // Registered outputs; reset abandons any in-flight op with all outputs low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr  <= 8'h00;
         mem_wdata <= 8'h00;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         rf_waddr  <= 2'd0;
         rf_wdata  <= 8'h00;
         rf_wr_en  <= 1'b0;
         pc_load   <= 1'b0;
         pc_value  <= 8'h00;
         done      <= 1'b0;
         stk_ovf   <= 1'b0;
         stk_unf   <= 1'b0;
      end else begin
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_we    <= mem_we_nxt;
         mem_re    <= mem_re_nxt;
         rf_waddr  <= rf_waddr_nxt;
         rf_wdata  <= rf_wdata_nxt;
         rf_wr_en  <= rf_wr_en_nxt;
         pc_load   <= pc_load_nxt;
         pc_value  <= pc_value_nxt;
         done      <= done_nxt;
         stk_ovf   <= ovf_nxt;
         stk_unf   <= unf_nxt;
      end
   end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Multi-cycle stack sequencer for the 8-bit pipelined processor. Executes PUSH, POP, CALL and RET against data memory. Drives the register file write port for R3 (stack pointer) and POP destinations. Sits in the MEM stage directly upstream of the register file's write port; the pipeline stalls while it is busy.

## Interface
Parameters:
- `SP_INIT`, 8'hFF: stack pointer reset/empty value; must match the register file's R3 reset value.
- `SP_REG`, 2'd3: register index holding the stack pointer.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `op_valid` in 1: stack operation request.
- `op_ready` out 1: high only in IDLE; the operation is accepted on `op_valid && op_ready`.
- `op_code` in 2: 0=PUSH, 1=POP, 2=CALL, 3=RET.
- `src_data` in 8: PUSH value, or CALL target address.
- `ret_addr` in 8: PC+1, pushed by CALL.
- `dst_reg` in 2: POP destination register.
- `sp_in` in 8: current SP (register file `SP` output).
- `mem_addr` out 8, `mem_wdata` out 8, `mem_we` out 1, `mem_re` out 1: data memory request.
- `mem_rdata` in 8, `mem_ready` in 1: memory response/acknowledge.
- `rf_waddr` out 2, `rf_wdata` out 8, `rf_wr_en` out 1: register file write port.
- `pc_load` out 1, `pc_value` out 8: PC redirect for CALL/RET.
- `done` out 1: single-cycle pulse in the final cycle of an operation.
- `stk_ovf` out 1, `stk_unf` out 1: sticky overflow/underflow flags.

## Operation
- Stack grows downward. SP points to the next free slot; empty is SP==8'hFF.
- PUSH: mem[SP] <= src_data; then R3 <= SP-1.
- POP: R3 <= SP+1; then R[dst_reg] <= mem[SP+1]. If dst_reg==3, the data write lands last and R3 ends holding the popped value.
- CALL: mem[SP] <= ret_addr; then R3 <= SP-1; then pc_load with pc_value=src_data.
- RET: R3 <= SP+1; then pc_load with pc_value=mem[SP+1].
- Bounds are checked at acceptance against `sp_in`:
  - PUSH/CALL with sp_in==8'h00 is overflow.
  - POP/RET with sp_in==8'hFF is underflow.
  - A rejected op is consumed with no memory access, no RF write and no `done`. The matching sticky flag sets on the next edge and clears only on reset.
- FSM states: IDLE, MEM, SP_WB, DATA_WB, PC_LD.
  - IDLE -> MEM on accepted legal op.
  - MEM -> SP_WB when `mem_ready`.
  - SP_WB -> DATA_WB (POP), PC_LD (CALL/RET) or IDLE (PUSH).
  - DATA_WB -> IDLE.
  - PC_LD -> IDLE.
- op_code, src_data, ret_addr, dst_reg and sp_in are captured in the accept cycle. Later input changes are ignored.
- SP arithmetic is 8-bit; wrap cannot occur because of the bounds checks.

## Timing
- In MEM, hold `mem_addr`/`mem_wdata`/`mem_we` or `mem_re` stable until `mem_ready` is sampled high. mem_addr = SP for writes, SP+1 for reads.
- `mem_rdata` is registered on the `mem_ready` edge.
- SP_WB: `rf_wr_en`=1, `rf_waddr`=SP_REG, for exactly one cycle.
- DATA_WB: `rf_wr_en`=1, `rf_waddr`=dst_reg, `rf_wdata`=captured read data.
- PC_LD: `pc_load`=1 for one cycle.
- `done` is asserted in the last state of each op (SP_WB for PUSH, DATA_WB for POP, PC_LD for CALL/RET).
- Latency with zero-wait memory (accept at T0): PUSH done T2; POP, CALL, RET done T3; `op_ready` returns at the next cycle. Each memory wait cycle adds one cycle.
- Outputs are registered, except `op_ready`, which is decoded from state.
- Reset (any time, including mid-op): state IDLE; all memory, RF and PC outputs 0; `done`=0; flags 0; `op_ready`=1. An in-flight op is abandoned and no partial RF write is issued.

## Structure
- Shared package holds the op_code constants (OP_PUSH..OP_RET), the FSM state encoding, and SP_INIT.
- Single module; no sub-module is warranted.
- The RF write-port mux (stack_ctrl vs. normal writeback) lives outside this block; stack_ctrl has priority whenever `rf_wr_en` is high.

## Test plan
- Reset, then PUSH 8'hA5 with sp_in=FF, mem_ready tied 1 -> mem write addr FF data A5 at T1; rf write R3=FE at T2 with `done`.
- POP dst=1 with sp_in=FE, mem_rdata=3C -> mem_re addr FF; R3=FF at T2; R1=3C at T3 with `done`.
- CALL src_data=40, ret_addr=11, sp_in=FF -> mem[FF]=11; R3=FE; pc_load pc_value=40. Then RET with sp_in=FE, mem_rdata=11 -> R3=FF; pc_value=11.
- POP with sp_in=FF -> no mem_re, no rf_wr_en, `stk_unf`=1 stays set. PUSH with sp_in=00 -> `stk_ovf`=1.
- PUSH with mem_ready held low 3 cycles -> request held stable; SP write follows the ready edge; `done` at T5.
- Assert rst during MEM of a POP -> all outputs 0 immediately; no RF write afterwards; the next op runs normally.
